// File: rtl/axi_mem_arb_pkg.sv
// Shared state types and default widths for the
// two-master AXI memory arbiter.
package axi_mem_arb_pkg;

    localparam int DEF_ID_WIDTH   = 6;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/axi_mem_arb_if.sv
// One full AXI4 port; the master modport drives the
// request channels, the slave modport the responses.
interface axi_mem_arb_if
    import axi_mem_arb_pkg::*;
#(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_mem_arb_rr_arb2.sv
// Two-way round-robin arbiter with a registered
// last-grant pointer and a one-hot grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // last=1 means master 1 won most recently, so master 0 is favoured
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last <= 1'b1;
        end else if (en && |req) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/axi_mem_arb.sv
// Shares one AXI4 memory port between two masters with
// independent round-robin ownership of the write and read paths.
module axi_mem_arb
    import axi_mem_arb_pkg::*;
#(
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_init_done,
    axi_mem_arb_if.slave  s0,
    axi_mem_arb_if.slave  s1,
    axi_mem_arb_if.master m,
    output logic          o_wr_owner,
    output logic          o_rd_owner
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    wr_state_e wr_state;
    rd_state_e rd_state;

    logic [1:0] wr_req;
    logic [1:0] wr_gnt;
    logic [1:0] rd_req;
    logic [1:0] rd_gnt;
    logic       wr_en;
    logic       rd_en;

    logic wr_addr;
    logic wr_data;
    logic wr_resp;
    logic rd_addr;
    logic rd_data;

    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;

    assign wr_req = {s1.awvalid, s0.awvalid};
    assign rd_req = {s1.arvalid, s0.arvalid};
    assign wr_en  = (wr_state == W_IDLE) && i_init_done;
    assign rd_en  = (rd_state == R_IDLE) && i_init_done;

    rr_arb2 u_wr_arb (
        .clk  (clk),
        .rstn (rstn),
        .en   (wr_en),
        .req  (wr_req),
        .gnt  (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk  (clk),
        .rstn (rstn),
        .en   (rd_en),
        .req  (rd_req),
        .gnt  (rd_gnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state   <= W_IDLE;
            o_wr_owner <= 1'b0;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (wr_en && |wr_req) begin
                        o_wr_owner <= wr_gnt[1];
                        wr_state   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (m.awvalid && m.awready) wr_state <= W_DATA;
                end
                W_DATA: begin
                    if (m.wvalid && m.wready && m.wlast) wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (m.bvalid && m.bready) wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state   <= R_IDLE;
            o_rd_owner <= 1'b0;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    if (rd_en && |rd_req) begin
                        o_rd_owner <= rd_gnt[1];
                        rd_state   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m.arvalid && m.arready) rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (m.rvalid && m.rready && m.rlast) rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign wr_addr = (wr_state == W_ADDR);
    assign wr_data = (wr_state == W_DATA);
    assign wr_resp = (wr_state == W_RESP);
    assign rd_addr = (rd_state == R_ADDR);
    assign rd_data = (rd_state == R_DATA);

    // Payloads follow the owner; only the valids/readies are phase-gated
    assign aw_id   = o_wr_owner ? s1.awid   : s0.awid;
    assign aw_addr = o_wr_owner ? s1.awaddr : s0.awaddr;
    assign w_data  = o_wr_owner ? s1.wdata  : s0.wdata;
    assign w_strb  = o_wr_owner ? s1.wstrb  : s0.wstrb;
    assign ar_id   = o_rd_owner ? s1.arid   : s0.arid;
    assign ar_addr = o_rd_owner ? s1.araddr : s0.araddr;

    assign m.awid    = aw_id;
    assign m.awaddr  = aw_addr;
    assign m.awlen   = o_wr_owner ? s1.awlen   : s0.awlen;
    assign m.awsize  = o_wr_owner ? s1.awsize  : s0.awsize;
    assign m.awburst = o_wr_owner ? s1.awburst : s0.awburst;
    assign m.awvalid = wr_addr && (o_wr_owner ? s1.awvalid : s0.awvalid);
    assign s0.awready = wr_addr && !o_wr_owner && m.awready;
    assign s1.awready = wr_addr &&  o_wr_owner && m.awready;

    assign m.wdata  = w_data;
    assign m.wstrb  = w_strb;
    assign m.wlast  = o_wr_owner ? s1.wlast : s0.wlast;
    assign m.wvalid = wr_data && (o_wr_owner ? s1.wvalid : s0.wvalid);
    assign s0.wready = wr_data && !o_wr_owner && m.wready;
    assign s1.wready = wr_data &&  o_wr_owner && m.wready;

    assign s0.bid    = m.bid;
    assign s1.bid    = m.bid;
    assign s0.bresp  = m.bresp;
    assign s1.bresp  = m.bresp;
    assign s0.bvalid = wr_resp && !o_wr_owner && m.bvalid;
    assign s1.bvalid = wr_resp &&  o_wr_owner && m.bvalid;
    assign m.bready  = wr_resp && (o_wr_owner ? s1.bready : s0.bready);

    assign m.arid    = ar_id;
    assign m.araddr  = ar_addr;
    assign m.arlen   = o_rd_owner ? s1.arlen   : s0.arlen;
    assign m.arsize  = o_rd_owner ? s1.arsize  : s0.arsize;
    assign m.arburst = o_rd_owner ? s1.arburst : s0.arburst;
    assign m.arvalid = rd_addr && (o_rd_owner ? s1.arvalid : s0.arvalid);
    assign s0.arready = rd_addr && !o_rd_owner && m.arready;
    assign s1.arready = rd_addr &&  o_rd_owner && m.arready;

    assign s0.rid    = m.rid;
    assign s1.rid    = m.rid;
    assign s0.rdata  = m.rdata;
    assign s1.rdata  = m.rdata;
    assign s0.rresp  = m.rresp;
    assign s1.rresp  = m.rresp;
    assign s0.rlast  = m.rlast;
    assign s1.rlast  = m.rlast;
    assign s0.rvalid = rd_data && !o_rd_owner && m.rvalid;
    assign s1.rvalid = rd_data &&  o_rd_owner && m.rvalid;
    assign m.rready  = rd_data && (o_rd_owner ? s1.rready : s0.rready);

endmodule

// File: tb/tb_axi_mem_arb.sv
// Directed bench for axi_mem_arb: init gating, round-robin,
// bursts, concurrency, backpressure and mid-burst reset.
module tb_axi_mem_arb;

    logic clk;
    logic rstn;
    logic i_init_done;
    logic o_wr_owner;
    logic o_rd_owner;

    int errors = 0;
    int checks = 0;
    int k;
    int stall;
    logic adv;
    logic [63:0] rx[$];
    logic [63:0] wexp [4] = '{64'h11, 64'h22, 64'h33, 64'h44};

    axi_mem_arb_if s0_if ();
    axi_mem_arb_if s1_if ();
    axi_mem_arb_if m_if ();

    axi_mem_arb dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_init_done (i_init_done),
        .s0          (s0_if),
        .s1          (s1_if),
        .m           (m_if),
        .o_wr_owner  (o_wr_owner),
        .o_rd_owner  (o_rd_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_masters();
        s0_if.awid = '0; s0_if.awaddr = '0; s0_if.awlen = '0;
        s0_if.awsize = 3'd3; s0_if.awburst = 2'd1; s0_if.awvalid = 0;
        s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wlast = 0;
        s0_if.wvalid = 0; s0_if.bready = 0;
        s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0;
        s0_if.arsize = 3'd3; s0_if.arburst = 2'd1; s0_if.arvalid = 0;
        s0_if.rready = 0;
        s1_if.awid = '0; s1_if.awaddr = '0; s1_if.awlen = '0;
        s1_if.awsize = 3'd3; s1_if.awburst = 2'd1; s1_if.awvalid = 0;
        s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wlast = 0;
        s1_if.wvalid = 0; s1_if.bready = 0;
        s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0;
        s1_if.arsize = 3'd3; s1_if.arburst = 2'd1; s1_if.arvalid = 0;
        s1_if.rready = 0;
    endtask

    initial begin
        rstn = 0;
        i_init_done = 0;
        clr_masters();
        m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
        m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
        m_if.rlast = 0; m_if.rvalid = 0;
        s0_if.bready = 1; s0_if.rready = 1;
        #1;
        chk("rst_s0_awready", s0_if.awready, 0);
        chk("rst_s0_arready", s0_if.arready, 0);
        chk("rst_m_bready", m_if.bready, 0);
        chk("rst_m_rready", m_if.rready, 0);
        chk("rst_wr_owner", o_wr_owner, 0);
        chk("rst_rd_owner", o_rd_owner, 0);
        tick; tick;
        rstn = 1;

        // init gate
        s0_if.awvalid = 1; s0_if.awid = 6'd5;
        s0_if.awaddr = 32'h1000; s0_if.awlen = 8'd0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("gate_m_awvalid", m_if.awvalid, 0);
        end
        i_init_done = 1;
        #1;
        chk("gate_same_cycle", m_if.awvalid, 0);
        tick;
        chk("gate_m_awvalid_up", m_if.awvalid, 1);
        chk("gate_awaddr", m_if.awaddr, 64'h1000);
        chk("gate_awid", m_if.awid, 5);
        chk("gate_owner", o_wr_owner, 0);
        chk("gate_s0_awready", s0_if.awready, 1);
        chk("gate_s1_awready", s1_if.awready, 0);
        tick;
        s0_if.awvalid = 0;
        s0_if.wvalid = 1; s0_if.wdata = 64'hAA;
        s0_if.wstrb = 8'hFF; s0_if.wlast = 1;
        #1;
        chk("w0_m_wvalid", m_if.wvalid, 1);
        chk("w0_m_wdata", m_if.wdata, 64'hAA);
        chk("w0_s0_wready", s0_if.wready, 1);
        tick;
        s0_if.wvalid = 0; s0_if.wlast = 0;
        m_if.bvalid = 1; m_if.bid = 6'd5; m_if.bresp = 2'd0;
        #1;
        chk("w0_s0_bvalid", s0_if.bvalid, 1);
        chk("w0_s1_bvalid", s1_if.bvalid, 0);
        chk("w0_s0_bid", s0_if.bid, 5);
        chk("w0_m_bready", m_if.bready, 1);
        tick;
        m_if.bvalid = 0;
        #1;
        chk("w0_idle_awvalid", m_if.awvalid, 0);

        // s1 four-beat write burst
        s1_if.bready = 1;
        s1_if.awvalid = 1; s1_if.awid = 6'h2A;
        s1_if.awaddr = 32'h2000; s1_if.awlen = 8'd3;
        tick;
        chk("wb_owner", o_wr_owner, 1);
        chk("wb_m_awid", m_if.awid, 64'h2A);
        chk("wb_m_awlen", m_if.awlen, 3);
        chk("wb_s1_awready", s1_if.awready, 1);
        chk("wb_s0_awready", s0_if.awready, 0);
        tick;
        s1_if.awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            s1_if.wvalid = 1; s1_if.wdata = wexp[i];
            s1_if.wstrb = 8'hFF; s1_if.wlast = (i == 3);
            #1;
            chk("wb_m_wvalid", m_if.wvalid, 1);
            chk("wb_m_wdata", m_if.wdata, wexp[i]);
            chk("wb_m_wlast", m_if.wlast, (i == 3));
            chk("wb_s0_wready", s0_if.wready, 0);
            tick;
        end
        s1_if.wvalid = 0; s1_if.wlast = 0;
        m_if.bvalid = 1; m_if.bid = 6'h2A; m_if.bresp = 2'd0;
        #1;
        chk("wb_s1_bvalid", s1_if.bvalid, 1);
        chk("wb_s1_bresp", s1_if.bresp, 0);
        chk("wb_s0_bvalid", s0_if.bvalid, 0);
        tick;
        m_if.bvalid = 0;

        // simultaneous reads: 0, 1, 0
        s0_if.arvalid = 1; s0_if.arid = 6'd1; s0_if.arlen = 8'd0;
        s1_if.arvalid = 1; s1_if.arid = 6'd2; s1_if.arlen = 8'd0;
        s1_if.rready = 1;
        tick;
        chk("rr0_owner", o_rd_owner, 0);
        chk("rr0_m_arid", m_if.arid, 1);
        chk("rr0_s0_arready", s0_if.arready, 1);
        chk("rr0_s1_arready", s1_if.arready, 0);
        tick;
        m_if.rvalid = 1; m_if.rlast = 1; m_if.rdata = 64'h5A; m_if.rid = 6'd1;
        #1;
        chk("rr0_s0_rvalid", s0_if.rvalid, 1);
        chk("rr0_s1_rvalid", s1_if.rvalid, 0);
        chk("rr0_s0_rdata", s0_if.rdata, 64'h5A);
        tick;
        m_if.rvalid = 0;
        #1;
        chk("rr0_idle_arvalid", m_if.arvalid, 0);
        tick;
        chk("rr1_owner", o_rd_owner, 1);
        chk("rr1_m_arid", m_if.arid, 2);
        tick;
        m_if.rvalid = 1; m_if.rdata = 64'h6B; m_if.rid = 6'd2;
        #1;
        chk("rr1_s1_rvalid", s1_if.rvalid, 1);
        chk("rr1_s0_rvalid", s0_if.rvalid, 0);
        tick;
        m_if.rvalid = 0;
        tick;
        chk("rr2_owner", o_rd_owner, 0);
        tick;
        m_if.rvalid = 1; m_if.rdata = 64'h7C; m_if.rid = 6'd1;
        tick;
        m_if.rvalid = 0; m_if.rlast = 0;
        s0_if.arvalid = 0; s1_if.arvalid = 0;
        #1;
        chk("rr2_idle_arvalid", m_if.arvalid, 0);

        // s0 8-beat read alongside s1 single write, with backpressure
        s0_if.arvalid = 1; s0_if.arid = 6'd3;
        s0_if.araddr = 32'h3000; s0_if.arlen = 8'd7;
        s1_if.awvalid = 1; s1_if.awid = 6'h11; s1_if.awlen = 8'd0;
        tick;
        chk("cc_rd_owner", o_rd_owner, 0);
        chk("cc_wr_owner", o_wr_owner, 1);
        chk("cc_m_araddr", m_if.araddr, 64'h3000);
        tick;
        s0_if.arvalid = 0; s1_if.awvalid = 0;
        s1_if.wvalid = 1; s1_if.wlast = 1; s1_if.wdata = 64'h77;
        m_if.rvalid = 1; m_if.rid = 6'd3; m_if.rdata = 64'h100; m_if.rlast = 0;
        #1;
        chk("cc_m_wdata", m_if.wdata, 64'h77);
        chk("cc_s1_rvalid", s1_if.rvalid, 0);
        if (s0_if.rvalid && s0_if.rready) rx.push_back(s0_if.rdata);
        tick;
        s1_if.wvalid = 0; s1_if.wlast = 0;
        m_if.bvalid = 1; m_if.bid = 6'h11;
        m_if.rdata = 64'h101;
        #1;
        chk("cc_s1_bvalid", s1_if.bvalid, 1);
        chk("cc_s0_bvalid", s0_if.bvalid, 0);
        chk("cc_s1_bid", s1_if.bid, 64'h11);
        if (s0_if.rvalid && s0_if.rready) rx.push_back(s0_if.rdata);
        tick;
        m_if.bvalid = 0;
        k = 2;
        stall = 0;
        for (int g = 0; g < 40 && k < 8; g++) begin
            m_if.rvalid = 1;
            m_if.rdata = 64'h100 + 64'(k);
            m_if.rlast = (k == 7);
            if (k == 3 && stall < 5) begin
                s0_if.rready = 0;
                stall++;
            end else begin
                s0_if.rready = 1;
            end
            #1;
            if (!s0_if.rready) chk("bp_m_rready", m_if.rready, 0);
            if (s0_if.rvalid && s0_if.rready) rx.push_back(s0_if.rdata);
            adv = m_if.rvalid && m_if.rready;
            tick;
            if (adv) k++;
        end
        m_if.rvalid = 0; m_if.rlast = 0; s0_if.rready = 1;
        #1;
        chk("bp_stall_cycles", stall, 5);
        chk("bp_beat_count", rx.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("bp_beat_data", rx[i], 64'h100 + 64'(i));
        end
        chk("bp_rd_idle", s0_if.arready, 0);

        // reset during beat 2 of a 4-beat write
        s0_if.awvalid = 1; s0_if.awid = 6'd4; s0_if.awlen = 8'd3;
        tick;
        tick;
        s0_if.awvalid = 0;
        s0_if.wvalid = 1; s0_if.wdata = 64'h1; s0_if.wstrb = 8'hFF;
        tick;
        s0_if.wdata = 64'h2;
        #1;
        chk("mr_beat2_wvalid", m_if.wvalid, 1);
        #2;
        rstn = 0;
        #1;
        chk("mr_m_wvalid", m_if.wvalid, 0);
        chk("mr_s0_wready", s0_if.wready, 0);
        chk("mr_m_awvalid", m_if.awvalid, 0);
        tick;
        rstn = 1;
        tick;
        chk("mr_post_wvalid", m_if.wvalid, 0);
        chk("mr_post_awvalid", m_if.awvalid, 0);
        s0_if.awvalid = 1; s0_if.awlen = 8'd0;
        s0_if.wvalid = 0;
        tick;
        chk("mr_regrant_awvalid", m_if.awvalid, 1);
        chk("mr_regrant_owner", o_wr_owner, 0);
        i_init_done = 0;
        tick;
        s0_if.awvalid = 0;
        s0_if.wvalid = 1; s0_if.wlast = 1;
        #1;
        chk("id_drop_s0_wready", s0_if.wready, 1);
        tick;
        s0_if.wvalid = 0; s0_if.wlast = 0;
        m_if.bvalid = 1;
        #1;
        chk("id_drop_s0_bvalid", s0_if.bvalid, 1);
        tick;
        m_if.bvalid = 0;
        s0_if.awvalid = 1;
        tick;
        chk("id_low_blocks", m_if.awvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
